// File: rtl/bram_ctrl_param.sv
// Parametrised tester BRAM controller: TEMPLATE/FF/TC slot stores plus a
// linear, tagged INPUT buffer with replay, occupancy flags, template-change
// detection and sticky error reporting. One command at a time; READY gates it.
module bram_ctrl_param #(
  parameter int DATA_W        = 128,
  parameter int NUM_TEMPLATES = 4,
  parameter int TSEL_W        = 2,
  parameter int INPUT_DEPTH   = 256,
  parameter int INPUT_AW      = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                INPUT_WRITE,
  input  logic                TEMPLATE_WRITE,
  input  logic                FF_WRITE,
  input  logic                TC_WRITE,
  input  logic                INPUT_READ,
  input  logic                TEMPLATE_READ,
  input  logic                FF_READ,
  input  logic                TC_READ,
  input  logic [TSEL_W-1:0]   TEMPLATE_BITS,
  input  logic [DATA_W-1:0]   WRITE_DATA,
  input  logic                RESET_READ_COUNTER,
  input  logic                CLEAR_INPUT,
  input  logic                CLR_ERR,
  output logic [DATA_W-1:0]   READ_DATA,
  output logic [TSEL_W-1:0]   READ_TAG,
  output logic                TEMPLATE_CHANGE,
  output logic                READY,
  output logic                INPUT_EMPTY,
  output logic                INPUT_FULL,
  output logic [INPUT_AW:0]   INPUT_COUNT,
  output logic [3:0]          ERR
);

  localparam logic [INPUT_AW:0] DEPTH_C = (INPUT_AW+1)'(INPUT_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD1, S_RD2} state_t;
  typedef enum logic [2:0] {
    OP_IN_WR, OP_TP_WR, OP_FF_WR, OP_TC_WR,
    OP_IN_RD, OP_TP_RD, OP_FF_RD, OP_TC_RD
  } op_t;

  logic [DATA_W-1:0]        tmpl_mem [NUM_TEMPLATES];
  logic [DATA_W-1:0]        ff_mem   [NUM_TEMPLATES];
  logic [DATA_W-1:0]        tc_mem   [NUM_TEMPLATES];
  logic [TSEL_W+DATA_W-1:0] in_mem   [INPUT_DEPTH];

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [TSEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [INPUT_AW:0]   addr_q;
  logic [INPUT_AW:0]   wr_count, rd_ptr, eff_wr, eff_rd;
  logic [DATA_W-1:0]   rd_data_p1;
  logic [TSEL_W-1:0]   rd_tag_p1;
  logic [TSEL_W-1:0]   last_tag;
  logic                last_tag_valid;
  logic                tchg_q;
  logic [3:0]          err_q, err_set;
  logic [7:0]          strobes;
  logic                any_strobe, multi_strobe, slot_op, sel_bad;
  logic                rewind, clear, accept;

  assign strobes = {INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE,
                    INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ};
  assign any_strobe   = |strobes;
  assign multi_strobe = (strobes & (strobes - 8'd1)) != 8'd0;
  // Every command except INPUT_READ consumes TEMPLATE_BITS as a slot or tag.
  assign slot_op      = |{strobes[7:4], strobes[2:0]};

  generate
    if (NUM_TEMPLATES == (1 << TSEL_W)) begin : g_sel_full
      assign sel_bad = 1'b0;
    end else begin : g_sel_partial
      assign sel_bad = 32'(TEMPLATE_BITS) >= NUM_TEMPLATES;
    end
  endgenerate

  // Rewind/clear act at the accepting edge, so a same-cycle access sees them first.
  assign rewind = READY && (RESET_READ_COUNTER || CLEAR_INPUT);
  assign clear  = READY && CLEAR_INPUT;
  assign eff_wr = clear  ? '0 : wr_count;
  assign eff_rd = rewind ? '0 : rd_ptr;

  // Decode which store/direction a single strobe selects.
  always_comb begin
    op_d = OP_TC_RD;
    if (INPUT_WRITE)         op_d = OP_IN_WR;
    else if (TEMPLATE_WRITE) op_d = OP_TP_WR;
    else if (FF_WRITE)       op_d = OP_FF_WR;
    else if (TC_WRITE)       op_d = OP_TC_WR;
    else if (INPUT_READ)     op_d = OP_IN_RD;
    else if (TEMPLATE_READ)  op_d = OP_TP_RD;
    else if (FF_READ)        op_d = OP_FF_RD;
  end

  // Next-state, command acceptance and error detection.
  always_comb begin
    state_d = state_q;
    err_set = '0;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_strobe) begin
          if (multi_strobe || (slot_op && sel_bad)) err_set[2] = 1'b1;
          else if (INPUT_WRITE && (eff_wr == DEPTH_C)) err_set[0] = 1'b1;
          else if (INPUT_READ && (eff_rd == eff_wr))   err_set[1] = 1'b1;
          else begin
            accept  = 1'b1;
            state_d = (|strobes[7:4]) ? S_WR : S_RD1;
          end
        end
      end
      S_WR: begin
        state_d = S_IDLE;
        err_set[3] = any_strobe;
      end
      S_RD1: begin
        state_d = S_RD2;
        err_set[3] = any_strobe;
      end
      S_RD2: begin
        state_d = S_IDLE;
        err_set[3] = any_strobe;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, pointers, flags, read result and sticky errors.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= S_IDLE;
      op_q           <= OP_TC_RD;
      wr_count       <= '0;
      rd_ptr         <= '0;
      err_q          <= '0;
      last_tag       <= '0;
      last_tag_valid <= 1'b0;
      tchg_q         <= 1'b0;
      READ_DATA      <= '0;
      READ_TAG       <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (CLR_ERR ? 4'b0 : err_q) | err_set;
      tchg_q  <= 1'b0;
      if (accept) op_q <= op_d;
      if (clear)  wr_count <= '0;
      if (rewind) begin
        rd_ptr         <= '0;
        last_tag_valid <= 1'b0;
      end
      if (accept && INPUT_READ) rd_ptr <= eff_rd + 1'b1;
      if (state_q == S_WR && op_q == OP_IN_WR) wr_count <= addr_q + 1'b1;
      if (state_q == S_RD2) begin
        READ_DATA <= rd_data_p1;
        if (op_q == OP_IN_RD) begin
          READ_TAG       <= rd_tag_p1;
          tchg_q         <= !last_tag_valid || (rd_tag_p1 != last_tag);
          last_tag       <= rd_tag_p1;
          last_tag_valid <= 1'b1;
        end
      end
    end
  end

  // p0: command operands captured on acceptance.
  always_ff @(posedge CLK) begin
    if (accept) begin
      sel_q   <= TEMPLATE_BITS;
      wdata_q <= WRITE_DATA;
      addr_q  <= INPUT_WRITE ? eff_wr : eff_rd;
    end
  end

  // Store write on the WR edge; a reset at that edge drops the write.
  always_ff @(posedge CLK) begin
    if (state_q == S_WR && RST_N) begin
      case (op_q)
        OP_IN_WR: in_mem[addr_q[INPUT_AW-1:0]] <= {sel_q, wdata_q};
        OP_TP_WR: tmpl_mem[sel_q] <= wdata_q;
        OP_FF_WR: ff_mem[sel_q]   <= wdata_q;
        OP_TC_WR: tc_mem[sel_q]   <= wdata_q;
        default: ;
      endcase
    end
  end

  // p1: synchronous BRAM read register, loaded on the RD1 edge.
  always_ff @(posedge CLK) begin
    if (state_q == S_RD1) begin
      case (op_q)
        OP_IN_RD: {rd_tag_p1, rd_data_p1} <= in_mem[addr_q[INPUT_AW-1:0]];
        OP_TP_RD: rd_data_p1 <= tmpl_mem[sel_q];
        OP_FF_RD: rd_data_p1 <= ff_mem[sel_q];
        OP_TC_RD: rd_data_p1 <= tc_mem[sel_q];
        default: ;
      endcase
    end
  end

  assign READY           = (state_q == S_IDLE);
  assign TEMPLATE_CHANGE = tchg_q;
  assign INPUT_EMPTY     = (rd_ptr == wr_count);
  assign INPUT_FULL      = (wr_count == DEPTH_C);
  assign INPUT_COUNT     = wr_count;
  assign ERR             = err_q;

endmodule

// File: tb/tb_bram_ctrl_param.sv
// Directed, table-driven bench for bram_ctrl_param with hand sequences for
// replay, fill/overflow, multi-strobe, busy-strobe and mid-read reset.
module tb_bram_ctrl_param;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE;
  logic         INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ;
  logic [1:0]   TEMPLATE_BITS;
  logic [127:0] WRITE_DATA;
  logic         RESET_READ_COUNTER, CLEAR_INPUT, CLR_ERR;
  logic [127:0] READ_DATA;
  logic [1:0]   READ_TAG;
  logic         TEMPLATE_CHANGE, READY, INPUT_EMPTY, INPUT_FULL;
  logic [8:0]   INPUT_COUNT;
  logic [3:0]   ERR;

  bram_ctrl_param dut (
    .CLK(CLK), .RST_N(RST_N),
    .INPUT_WRITE(INPUT_WRITE), .TEMPLATE_WRITE(TEMPLATE_WRITE),
    .FF_WRITE(FF_WRITE), .TC_WRITE(TC_WRITE),
    .INPUT_READ(INPUT_READ), .TEMPLATE_READ(TEMPLATE_READ),
    .FF_READ(FF_READ), .TC_READ(TC_READ),
    .TEMPLATE_BITS(TEMPLATE_BITS), .WRITE_DATA(WRITE_DATA),
    .RESET_READ_COUNTER(RESET_READ_COUNTER), .CLEAR_INPUT(CLEAR_INPUT),
    .CLR_ERR(CLR_ERR),
    .READ_DATA(READ_DATA), .READ_TAG(READ_TAG),
    .TEMPLATE_CHANGE(TEMPLATE_CHANGE), .READY(READY),
    .INPUT_EMPTY(INPUT_EMPTY), .INPUT_FULL(INPUT_FULL),
    .INPUT_COUNT(INPUT_COUNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  localparam int W_IN = 1, W_TP = 2, W_FF = 3, W_TC = 4;
  localparam int R_IN = 5, R_TP = 6, R_FF = 7, R_TC = 8;

  localparam logic [127:0] X  = 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF;
  localparam logic [127:0] A  = 128'hA5A5A5A5000000001111111122222222;
  localparam logic [127:0] C3 = 128'hC1230000000000000000000DEADBEEF;
  localparam logic [127:0] F3 = 128'hF3F3F3F3F3F3F3F30000000000000003;
  localparam logic [127:0] F0 = 128'hF0F0F0F0F0F0F0F00000000000000000;
  localparam logic [127:0] IA = 128'h11111111111111111111111111111111;
  localparam logic [127:0] IB = 128'h22222222222222222222222222222222;
  localparam logic [127:0] IC = 128'h33333333333333333333333333333333;
  localparam logic [127:0] Z  = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

  typedef struct {
    int           op;
    logic [1:0]   sel;
    logic [127:0] wdata;
    int           busy;
    bit           chk_data;
    logic [127:0] exp_data;
    logic [1:0]   exp_tag;
    logic         exp_tchg;
    logic [3:0]   exp_err;
    logic         exp_empty;
    logic [8:0]   exp_count;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int op, logic [1:0] sel, logic [127:0] wd, int busy,
                              bit cd, logic [127:0] ed, logic [1:0] et, logic tc,
                              logic [3:0] ee, logic em, logic [8:0] cnt);
    vec_t v;
    v.op = op; v.sel = sel; v.wdata = wd; v.busy = busy; v.chk_data = cd;
    v.exp_data = ed; v.exp_tag = et; v.exp_tchg = tc; v.exp_err = ee;
    v.exp_empty = em; v.exp_count = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_strobes();
    INPUT_WRITE = 0; TEMPLATE_WRITE = 0; FF_WRITE = 0; TC_WRITE = 0;
    INPUT_READ = 0; TEMPLATE_READ = 0; FF_READ = 0; TC_READ = 0;
    RESET_READ_COUNTER = 0; CLEAR_INPUT = 0; CLR_ERR = 0;
  endtask

  task automatic set_op(input int op);
    INPUT_WRITE    = (op == W_IN); TEMPLATE_WRITE = (op == W_TP);
    FF_WRITE       = (op == W_FF); TC_WRITE       = (op == W_TC);
    INPUT_READ     = (op == R_IN); TEMPLATE_READ  = (op == R_TP);
    FF_READ        = (op == R_FF); TC_READ        = (op == R_TC);
  endtask

  // Issue one command at a negedge, wait (bounded) for READY, check outputs.
  task automatic run_vec(input vec_t v, input string nm);
    int n;
    set_op(v.op);
    TEMPLATE_BITS = v.sel;
    WRITE_DATA    = v.wdata;
    @(negedge CLK);
    clear_strobes();
    n = 0;
    while (!READY && n < 8) begin
      n++;
      @(negedge CLK);
    end
    check({nm, ".busy"}, 128'(n), 128'(v.busy));
    if (v.chk_data) check({nm, ".data"}, READ_DATA, v.exp_data);
    check({nm, ".tag"},   128'(READ_TAG),        128'(v.exp_tag));
    check({nm, ".tchg"},  128'(TEMPLATE_CHANGE), 128'(v.exp_tchg));
    check({nm, ".err"},   128'(ERR),             128'(v.exp_err));
    check({nm, ".empty"}, 128'(INPUT_EMPTY),     128'(v.exp_empty));
    check({nm, ".count"}, 128'(INPUT_COUNT),     128'(v.exp_count));
  endtask

  // One-cycle pulse on a control input; READY must stay high.
  task automatic pulse_ctrl(input int which, input string nm);
    CLR_ERR            = (which == 0);
    RESET_READ_COUNTER = (which == 1);
    CLEAR_INPUT        = (which == 2);
    @(negedge CLK);
    clear_strobes();
    check({nm, ".ready"}, 128'(READY), 128'd1);
  endtask

  initial begin
    clear_strobes();
    TEMPLATE_BITS = 0;
    WRITE_DATA    = '0;
    RST_N         = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1;
    check("rst.ready", 128'(READY), 128'd1);
    check("rst.data",  READ_DATA, 128'd0);
    check("rst.tag",   128'(READ_TAG), 128'd0);
    check("rst.tchg",  128'(TEMPLATE_CHANGE), 128'd0);
    check("rst.empty", 128'(INPUT_EMPTY), 128'd1);
    check("rst.full",  128'(INPUT_FULL), 128'd0);
    check("rst.count", 128'(INPUT_COUNT), 128'd0);
    check("rst.err",   128'(ERR), 128'd0);

    //               op    sel wdata busy cd exp  tag tc err     em cnt
    tbl.push_back(mk(W_TC, 0, X,  1, 0, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(R_TC, 0, 0,  2, 1, X,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(W_TP, 0, A,  1, 0, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(W_TP, 3, C3, 1, 0, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(W_FF, 3, F3, 1, 0, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(W_FF, 0, F0, 1, 0, 0,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(R_TP, 3, 0,  2, 1, C3, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(R_TP, 0, 0,  2, 1, A,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(R_FF, 3, 0,  2, 1, F3, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(R_TC, 0, 0,  2, 1, X,  0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(W_IN, 0, IA, 1, 0, 0,  0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(W_IN, 0, IB, 1, 0, 0,  0, 0, 4'b0000, 0, 2));
    tbl.push_back(mk(W_IN, 3, IC, 1, 0, 0,  0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(R_IN, 0, 0,  2, 1, IA, 0, 1, 4'b0000, 0, 3));
    tbl.push_back(mk(R_IN, 0, 0,  2, 1, IB, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(R_IN, 0, 0,  2, 1, IC, 3, 1, 4'b0000, 1, 3));
    tbl.push_back(mk(R_IN, 0, 0,  0, 1, IC, 3, 0, 4'b0010, 1, 3));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // Replay and clear of the INPUT buffer
    pulse_ctrl(0, "clrerr1");
    check("clrerr1.err", 128'(ERR), 128'd0);
    pulse_ctrl(1, "rewind");
    check("rewind.empty", 128'(INPUT_EMPTY), 128'd0);
    run_vec(mk(R_IN, 0, 0, 2, 1, IA, 0, 1, 4'b0000, 0, 3), "replay");
    pulse_ctrl(2, "clrin");
    check("clrin.count", 128'(INPUT_COUNT), 128'd0);
    check("clrin.empty", 128'(INPUT_EMPTY), 128'd1);

    // Fill to capacity, then overflow
    for (int i = 0; i < 256; i++) begin
      INPUT_WRITE   = 1;
      TEMPLATE_BITS = 2'(i);
      WRITE_DATA    = 128'(i);
      @(negedge CLK);
      clear_strobes();
      @(negedge CLK);
    end
    check("fill.full",  128'(INPUT_FULL), 128'd1);
    check("fill.count", 128'(INPUT_COUNT), 128'd256);
    run_vec(mk(W_IN, 0, Z, 0, 0, 0, 0, 0, 4'b0001, 0, 256), "ovf");
    check("ovf.full", 128'(INPUT_FULL), 128'd1);
    pulse_ctrl(0, "clrerr2");
    pulse_ctrl(2, "clrin2");
    check("clrin2.err", 128'(ERR), 128'd0);

    // Two strobes together: nothing executes
    TC_WRITE = 1; FF_WRITE = 1; TEMPLATE_BITS = 0; WRITE_DATA = Z;
    @(negedge CLK);
    clear_strobes();
    check("multi.ready", 128'(READY), 128'd1);
    check("multi.err",   128'(ERR), 128'b0100);
    run_vec(mk(R_TC, 0, 0, 2, 1, X,  0, 0, 4'b0100, 1, 0), "multi.tc");
    run_vec(mk(R_FF, 0, 0, 2, 1, F0, 0, 0, 4'b0100, 1, 0), "multi.ff");

    // Strobe while busy in RD1
    TC_READ = 1; TEMPLATE_BITS = 0;
    @(negedge CLK);
    clear_strobes();
    check("busy.rd1", 128'(READY), 128'd0);
    FF_WRITE = 1; WRITE_DATA = Z;
    @(negedge CLK);
    clear_strobes();
    @(negedge CLK);
    check("busy.ready", 128'(READY), 128'd1);
    check("busy.data",  READ_DATA, X);
    check("busy.err",   128'(ERR), 128'b1100);
    run_vec(mk(R_FF, 0, 0, 2, 1, F0, 0, 0, 4'b1100, 1, 0), "busy.ff");

    // Reset while in RD1 aborts the read
    TEMPLATE_READ = 1; TEMPLATE_BITS = 3;
    @(negedge CLK);
    clear_strobes();
    check("rstrd.rd1", 128'(READY), 128'd0);
    RST_N = 0;
    @(negedge CLK);
    RST_N = 1;
    check("rstrd.ready", 128'(READY), 128'd1);
    check("rstrd.data",  READ_DATA, 128'd0);
    check("rstrd.err",   128'(ERR), 128'd0);
    run_vec(mk(R_TP, 3, 0, 2, 1, C3, 0, 0, 4'b0000, 1, 0), "after.rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
